// File: rtl/bla_request_arbiter.sv
// Round-robin arbiter that shares one bresenham_controller among NUM_REQ requesters.
// Optional watchdog abort of a stuck BUSY phase is enabled by defining BLA_ARB_WATCHDOG_EN.
module bla_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_vertice_num,
  input  logic [NUM_REQ*48-1:0]   req_coordinates,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      req_done,
  output logic                    bla_en,
  output logic                    vertice_num,
  output logic [47:0]             coordinates,
  input  logic                    bla_done,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RELEASE
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_param
    $error("bla_request_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES 1..65536");
  end

  state_t               r_state;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        r_owner;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_req_done;
  logic                 r_bla_en;
  logic                 r_vertice_num;
  logic [47:0]          r_coordinates;
  logic                 r_busy;

  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_cand;
  logic                 w_found;
  int                   w_idx;
  logic [PW-1:0]        w_next_ptr;
  logic                 w_wd_expire;
  logic [47:0]          w_coord_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_coord
    assign w_coord_arr[g] = req_coordinates[48*g +: 48];
  end

  // Scan from rr_ptr upward, wrapping, and keep the first requester found.
  always_comb begin
    w_win   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = PW'(w_idx);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_next_ptr = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + PW'(1);

`ifdef BLA_ARB_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
  logic        r_timeout_err;

  assign w_wd_expire = (r_state == S_BUSY) && !bla_done &&
                       (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_BUSY && !bla_done) r_wd_cnt <= r_wd_cnt + 16'd1;
      else                                r_wd_cnt <= '0;
      if (w_wd_expire) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_wd_expire = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_grant       <= '0;
      r_req_done    <= '0;
      r_bla_en      <= 1'b0;
      r_vertice_num <= 1'b0;
      r_coordinates <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_owner       <= w_win;
            r_grant       <= NUM_REQ'(1) << w_win;
            r_vertice_num <= req_vertice_num[w_win];
            r_coordinates <= w_coord_arr[w_win];
            r_bla_en      <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        // bla_done here is deliberately dropped: the engine has not started yet.
        S_ISSUE: begin
          r_bla_en <= 1'b0;
          r_state  <= S_BUSY;
        end
        S_BUSY: begin
          if (bla_done || w_wd_expire) begin
            r_req_done <= NUM_REQ'(1) << r_owner;
            r_grant    <= '0;
            r_rr_ptr   <= w_next_ptr;
            r_state    <= S_RELEASE;
          end
        end
        // One dead cycle lets the controller pass DONE_WAIT and IDLE before restarting.
        S_RELEASE: begin
          r_req_done <= '0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign req_done    = r_req_done;
  assign bla_en      = r_bla_en;
  assign vertice_num = r_vertice_num;
  assign coordinates = r_coordinates;
  assign busy        = r_busy;

endmodule

// File: tb/tb_bla_request_arbiter.sv
// Self-checking bench for bla_request_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=16).
// Expected owners come from a round-robin pointer model kept in the bench.
module tb_bla_request_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      req_vertice_num;
  logic [N*48-1:0]   req_coordinates;
  logic              bla_done;
  logic [N-1:0]      grant;
  logic [N-1:0]      req_done;
  logic              bla_en;
  logic              vertice_num;
  logic [47:0]       coordinates;
  logic              busy;
  logic              timeout_err;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  bla_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_vertice_num(req_vertice_num),
    .req_coordinates(req_coordinates), .grant(grant), .req_done(req_done),
    .bla_en(bla_en), .vertice_num(vertice_num), .coordinates(coordinates),
    .bla_done(bla_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rotate the request vector so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    dbl = {r, r} >> p;
    rot = dbl[N-1:0];
    for (int k = 0; k < N; k++)
      if (rot[k]) return (k + p) % N;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '1; bla_done = 1'b0; req_vertice_num = '1;
    req_coordinates = {$urandom, $urandom, $urandom};
    tick(); tick();
    total++; if (grant !== '0)       begin bad++; $display("FAIL rst_grant: got %b want 0", grant); end
    total++; if (req_done !== '0)    begin bad++; $display("FAIL rst_req_done: got %b want 0", req_done); end
    total++; if (bla_en !== 1'b0)    begin bad++; $display("FAIL rst_bla_en: got %b want 0", bla_en); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (coordinates !== '0) begin bad++; $display("FAIL rst_coord: got %h want 0", coordinates); end
    total++; if (vertice_num !== 1'b0) begin bad++; $display("FAIL rst_vnum: got %b want 0", vertice_num); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
    rst = 1'b0; req = '0; m_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    int w;
    req = 2'b01; req_vertice_num = '0; req_coordinates[47:0] = 48'h5555_FFFF_0101;
    w = pick(req, m_ptr);
    tick();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", grant); end
    total++; if (bla_en !== 1'b1) begin bad++; $display("FAIL single_bla_en: got %b want 1", bla_en); end
    total++; if (coordinates !== 48'h5555_FFFF_0101) begin bad++; $display("FAIL single_coord: got %h want 5555ffff0101", coordinates); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bla_en !== 1'b0 || req_done !== '0 || grant !== 2'b01)
        begin bad++; $display("FAIL single_wait: bla_en=%b req_done=%b grant=%b want 0/00/01", bla_en, req_done, grant); end
    end
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0; req = '0;
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL single_done: got %b want 01", req_done); end
    total++; if (grant !== 2'b00)    begin bad++; $display("FAIL single_grant_clr: got %b want 00", grant); end
    tick();
    total++; if (req_done !== '0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle: req_done=%b busy=%b want 00/0", req_done, busy); end
    m_ptr = (w + 1) % N;
  endtask

  task automatic test_round_robin();
    int w;
    logic [N-1:0] eg;
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      w  = pick(req, m_ptr);
      eg = N'(1) << w;
      tick();
      total++; if (grant !== eg || !$onehot(grant)) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", t, grant, eg); end
      tick();
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
      bla_done = 1'b1;
      tick();
      bla_done = 1'b0;
      total++; if (req_done !== eg) begin bad++; $display("FAIL rr_done[%0d]: got %b want %b", t, req_done, eg); end
      m_ptr = (w + 1) % N;
      tick();
      total++; if (grant !== '0) begin bad++; $display("FAIL rr_idle_grant[%0d]: got %b want 00", t, grant); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_hold_data();
    req = 2'b01; req_vertice_num = '0; req_coordinates[47:0] = 48'h5555_FFFF_0101;
    tick();
    req_coordinates[47:0] = '0; req_vertice_num = '1;
    tick();
    req = '0;
    total++; if (coordinates !== 48'h5555_FFFF_0101) begin bad++; $display("FAIL hold_coord: got %h want 5555ffff0101", coordinates); end
    total++; if (vertice_num !== 1'b0) begin bad++; $display("FAIL hold_vnum: got %b want 0", vertice_num); end
    tick(); tick();
    total++; if (busy !== 1'b1 || grant !== 2'b01) begin bad++; $display("FAIL hold_no_abort: busy=%b grant=%b want 1/01", busy, grant); end
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0;
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL hold_done: got %b want 01", req_done); end
    total++; if (coordinates !== 48'h5555_FFFF_0101) begin bad++; $display("FAIL hold_coord_rel: got %h want 5555ffff0101", coordinates); end
    m_ptr = 1;
    tick();
  endtask

  task automatic test_back_to_back();
    int w;
    req = 2'b01;
    w = pick(req, m_ptr);
    tick();
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0; req = 2'b11;
    total++; if (req_done !== '0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_issue_done: req_done=%b busy=%b want 00/1", req_done, busy); end
    tick(); tick();
    total++; if (req_done !== '0 || grant !== 2'b01) begin bad++; $display("FAIL b2b_still_busy: req_done=%b grant=%b want 00/01", req_done, grant); end
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0;
    m_ptr = (w + 1) % N;
    w = pick(req, m_ptr);
    total++; if (req_done !== 2'b01 || bla_en !== 1'b0) begin bad++; $display("FAIL b2b_t1: req_done=%b bla_en=%b want 01/0", req_done, bla_en); end
    tick();
    total++; if (bla_en !== 1'b0 || grant !== '0) begin bad++; $display("FAIL b2b_t2: bla_en=%b grant=%b want 0/00", bla_en, grant); end
    tick();
    total++; if (bla_en !== 1'b1 || grant !== (N'(1) << w)) begin bad++; $display("FAIL b2b_t3: bla_en=%b grant=%b want 1/%b", bla_en, grant, N'(1) << w); end
    req = '0;
    tick();
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0;
    m_ptr = (w + 1) % N;
    tick();
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0;
    total++; if (busy !== 1'b0 || req_done !== '0 || grant !== '0) begin bad++; $display("FAIL b2b_stray: busy=%b req_done=%b grant=%b want 0/00/00", busy, req_done, grant); end
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] eg;
    logic [47:0]  ec;
    logic         ev;
    for (int t = 0; t < 16; t++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      req_vertice_num = N'($urandom);
      req_coordinates = {$urandom, $urandom, $urandom};
      w  = pick(req, m_ptr);
      eg = N'(1) << w;
      ec = req_coordinates[48*w +: 48];
      ev = req_vertice_num[w];
      tick();
      total++; if (grant !== eg || bla_en !== 1'b1) begin bad++; $display("FAIL rnd_grant[%0d]: grant=%b bla_en=%b want %b/1", t, grant, bla_en, eg); end
      total++; if (coordinates !== ec || vertice_num !== ev) begin bad++; $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", t, coordinates, vertice_num, ec, ev); end
      req_coordinates = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) req = '0;
      tick();
      for (int d = 0; d < int'($urandom_range(0, 5)); d++) tick();
      total++; if (bla_en !== 1'b0 || grant !== eg || coordinates !== ec) begin bad++; $display("FAIL rnd_busy[%0d]: bla_en=%b grant=%b coord=%h", t, bla_en, grant, coordinates); end
      bla_done = 1'b1;
      tick();
      bla_done = 1'b0; req = '0;
      total++; if (req_done !== eg || grant !== '0) begin bad++; $display("FAIL rnd_done[%0d]: req_done=%b grant=%b want %b/00", t, req_done, grant, eg); end
      m_ptr = (w + 1) % N;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    req = 2'b10;
    tick(); tick();
    rst = 1'b1; bla_done = 1'b1;
    tick();
    total++; if (grant !== '0 || req_done !== '0 || busy !== 1'b0 || bla_en !== 1'b0)
      begin bad++; $display("FAIL midrst: grant=%b req_done=%b busy=%b bla_en=%b want all 0", grant, req_done, busy, bla_en); end
    rst = 1'b0; bla_done = 1'b0; req = '0; m_ptr = 0;
    tick();
    total++; if (req_done !== '0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_after: req_done=%b busy=%b want 00/0", req_done, busy); end
  endtask

  task automatic test_watchdog();
    req = 2'b01;
    tick();
    req = '0;
`ifdef BLA_ARB_WATCHDOG_EN
    for (int i = 0; i < TO; i++) begin
      tick();
      total++; if (req_done !== '0 || timeout_err !== 1'b0) begin bad++; $display("FAIL wd_early[%0d]: req_done=%b timeout=%b want 00/0", i, req_done, timeout_err); end
    end
    tick();
    total++; if (timeout_err !== 1'b1 || req_done !== 2'b01) begin bad++; $display("FAIL wd_fire: timeout=%b req_done=%b want 1/01", timeout_err, req_done); end
    tick();
    total++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wd_sticky: timeout=%b busy=%b want 1/0", timeout_err, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_clear: got %b want 0", timeout_err); end
    m_ptr = 0;
    tick();
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      total++; if (busy !== 1'b1 || req_done !== '0 || timeout_err !== 1'b0)
        begin bad++; $display("FAIL nowd_hold[%0d]: busy=%b req_done=%b timeout=%b want 1/00/0", i, busy, req_done, timeout_err); end
    end
    bla_done = 1'b1;
    tick();
    bla_done = 1'b0;
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL nowd_done: got %b want 01", req_done); end
    m_ptr = 1;
    tick();
`endif
  endtask

  initial begin
    req = '0; req_vertice_num = '0; req_coordinates = '0; bla_done = 1'b0; rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_data();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
